// File: rtl/csa_pkg.sv
// Shared types and sizing helpers for the carry-save accumulator.
package csa_pkg;

    typedef enum logic [1:0] {
        ACCUM,
        RESOLVE,
        DONE
    } state_t;

    // Number of cycles the chunked ripple adder needs to resolve r bits.
    function automatic int unsigned nch_of(input int unsigned r, input int unsigned chunk);
        return (r + chunk - 1) / chunk;
    endfunction

endpackage

// File: rtl/csa_row.sv
// Combinational N-bit 3:2 compressor; carry output is pre-shifted so carry[0] is always 0.
module csa_row #(
    parameter int unsigned N = 20
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] c,
    output logic [N-1:0] sum,
    output logic [N-1:0] carry
);

    always_comb begin
        sum          = a ^ b ^ c;
        carry        = '0;
        carry[N-1:1] = (a[N-2:0] & b[N-2:0]) | (a[N-2:0] & c[N-2:0]) | (b[N-2:0] & c[N-2:0]);
    end

endmodule

// File: rtl/csa_accumulator.sv
// Streaming multi-operand adder: carry-save accumulation, then a chunked ripple resolve.
// Define CSA_SIGNED_EN for two's-complement operands (sign-extended); default is unsigned.
module csa_accumulator
    import csa_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned G     = 4,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W+G-1:0]   out_sum,
    output logic [G:0]       out_count,
    output logic             out_ovf
);

    localparam int unsigned R   = W + G;
    localparam int unsigned NCH = nch_of(R, CHUNK);
    localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [G:0]  CAP = {1'b1, {G{1'b0}}};

    state_t          state;
    logic [R-1:0]    s_q;
    logic [R-1:0]    c_q;
    logic [R-1:0]    x;
    logic [R-1:0]    s_nxt;
    logic [R-1:0]    c_nxt;
    logic [G:0]      count;
    logic            ovf;
    logic [R-1:0]    sum_q;
    logic [R-1:0]    sum_nxt;
    logic [KW-1:0]   k;
    logic            cy;
    logic [CHUNK:0]  chunk_sum;

    always_comb begin
`ifdef CSA_SIGNED_EN
        x = {{G{in_data[W-1]}}, in_data};
`else
        x = {{G{1'b0}}, in_data};
`endif
    end

    csa_row #(.N(R)) u_row (
        .a     (s_q),
        .b     (c_q),
        .c     (x),
        .sum   (s_nxt),
        .carry (c_nxt)
    );

    // Chunk k of S and C are shifted down and truncated; a narrow last chunk sees zeros above bit R-1.
    always_comb begin
        chunk_sum = {1'b0, CHUNK'(s_q >> (k * CHUNK))}
                  + {1'b0, CHUNK'(c_q >> (k * CHUNK))}
                  + (CHUNK + 1)'(cy);
        sum_nxt = sum_q;
        for (int unsigned i = 0; i < R; i++) begin
            if (KW'(i / CHUNK) == k) begin
                sum_nxt[i] = chunk_sum[i % CHUNK];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ACCUM;
            s_q   <= '0;
            c_q   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            sum_q <= '0;
            k     <= '0;
            cy    <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        s_q <= s_nxt;
                        c_q <= c_nxt;
                        if (count == CAP) begin
                            ovf <= 1'b1;
                        end else begin
                            count <= count + 1'b1;
                        end
                        if (in_last) begin
                            state <= RESOLVE;
                            k     <= '0;
                            cy    <= 1'b0;
                        end
                    end
                end
                RESOLVE: begin
                    sum_q <= sum_nxt;
                    cy    <= chunk_sum[CHUNK];
                    if (k == KW'(NCH - 1)) begin
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        s_q   <= '0;
                        c_q   <= '0;
                        count <= '0;
                        ovf   <= 1'b0;
                        state <= ACCUM;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign out_sum   = sum_q;
    assign out_count = count;
    assign out_ovf   = ovf;

endmodule
